// File: rtl/int_div_unit_if.sv
// int_div_unit_if: operand/result bundle between the control unit and the divider
interface int_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             div_by_zero;
  logic             overflow;
  modport master (output start, is_signed, dividend, divisor,
                  input busy, done, lo, hi, div_by_zero, overflow);
  modport slave  (input start, is_signed, dividend, divisor,
                  output busy, done, lo, hi, div_by_zero, overflow);
endinterface

// File: rtl/int_div_unit.sv
// int_div_unit: radix-2 restoring DIV/DIVU, quotient to lo and remainder to hi
module int_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic rst,
  int_div_unit_if.slave d
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, lo_q, lo_d, hi_q, hi_d;
  logic sq_q, sq_d, sr_q, sr_d, ovp_q, ovp_d, dbz_q, dbz_d, ovf_q, ovf_d;
  logic a_neg, b_neg, accept;
  logic [WIDTH+1:0] trial;
  always_comb begin
    a_neg = d.is_signed & d.dividend[WIDTH-1];
    b_neg = d.is_signed & d.divisor[WIDTH-1];
    accept = d.start & (state_q == IDLE | state_q == DONE);
    // two guard bits keep the borrow unambiguous for large unsigned divisors
    trial = {1'b0, rem_q, quo_q[WIDTH-1]} - {2'b00, dvs_q};
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    lo_d = lo_q;
    hi_d = hi_q;
    sq_d = sq_q;
    sr_d = sr_q;
    ovp_d = ovp_q;
    dbz_d = dbz_q;
    ovf_d = ovf_q;
    if (accept && d.divisor == '0) begin
      state_d = DONE;
      lo_d = '1;
      hi_d = d.dividend;
      dbz_d = 1'b1;
      ovf_d = 1'b0;
    end else if (accept) begin
      state_d = RUN;
      cnt_d = '0;
      rem_d = '0;
      quo_d = a_neg ? -d.dividend : d.dividend;
      dvs_d = b_neg ? -d.divisor : d.divisor;
      sq_d = a_neg ^ b_neg;
      sr_d = a_neg;
      ovp_d = d.is_signed && d.dividend == {1'b1, {(WIDTH-1){1'b0}}} && d.divisor == '1;
    end else if (state_q == RUN) begin
      rem_d = trial[WIDTH+1] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == LAST ? FIX : RUN;
    end else if (state_q == FIX) begin
      lo_d = sq_q ? -quo_q : quo_q;
      hi_d = sr_q ? -rem_q : rem_q;
      ovf_d = ovp_q;
      dbz_d = 1'b0;
      state_d = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      lo_q <= '0;
      hi_q <= '0;
      sq_q <= 1'b0;
      sr_q <= 1'b0;
      ovp_q <= 1'b0;
      dbz_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      sq_q <= sq_d;
      sr_q <= sr_d;
      ovp_q <= ovp_d;
      dbz_q <= dbz_d;
      ovf_q <= ovf_d;
    end
  end
  assign d.busy = state_q == RUN || state_q == FIX;
  assign d.done = state_q == DONE;
  assign d.lo = lo_q;
  assign d.hi = hi_q;
  assign d.div_by_zero = dbz_q;
  assign d.overflow = ovf_q;
endmodule

// File: tb/tb_int_div_unit.sv
// tb_int_div_unit: scoreboard bench for the multi-cycle divider
module tb_int_div_unit;
  localparam int W = 32;
  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
    logic         ovf;
  } res_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int_div_unit_if #(.WIDTH(W)) bus();
  int_div_unit #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .rst(rst), .d(bus));
  res_t sbq[$];
  int n_cmp = 0;
  int n_err = 0;
  function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic s);
    res_t r;
    r.dbz = 1'b0;
    r.ovf = 1'b0;
    if (b == 0) begin
      r.lo = '1;
      r.hi = a;
      r.dbz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r.lo = 32'h8000_0000;
      r.hi = '0;
      r.ovf = 1'b1;
    end else if (s) begin
      r.lo = $signed(a) / $signed(b);
      r.hi = $signed(a) % $signed(b);
    end else begin
      r.lo = a / b;
      r.hi = a % b;
    end
    return r;
  endfunction
  function automatic res_t observed();
    return {bus.lo, bus.hi, bus.div_by_zero, bus.overflow};
  endfunction
  function automatic res_t pop_exp();
    res_t e;
    e = '0;
    if (sbq.size() > 0) e = sbq.pop_front();
    return e;
  endfunction
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic push);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    bus.is_signed = s;
    if (push) sbq.push_back(model(a, b, s));
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.dividend = $urandom;
    bus.divisor = $urandom;
    bus.is_signed = $urandom_range(0, 1);
  endtask
  task automatic wait_done(output int lat, output int nbusy);
    lat = 1;
    nbusy = 0;
    while (!bus.done && lat < 60) begin
      if (bus.busy) nbusy++;
      @(posedge clk);
      #1 lat++;
    end
    if (!bus.done) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: no done after %0d cycles", lat);
    end
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    bus.dividend = 32'd5;
    bus.divisor = 32'd1;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, observed()} !== '0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b lo=%h hi=%h dbz=%b ovf=%b, required all 0",
               bus.busy, bus.done, bus.lo, bus.hi, bus.div_by_zero, bus.overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", bus.busy, bus.done);
    end
  endtask
  task automatic test_basic();
    logic [W-1:0] ta[9], tb[9];
    logic ts[9];
    int lat, nbusy;
    res_t e;
    ta = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0};
    tb = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0};
    ts = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 5; i < 9; i++) begin
      ta[i] = $urandom;
      tb[i] = (i[0] ? $urandom : {16'h0, 16'($urandom)}) | 32'h1;
    end
    for (int i = 0; i < 9; i++) begin
      issue(ta[i], tb[i], ts[i], 1'b1);
      wait_done(lat, nbusy);
      e = pop_exp();
      n_cmp++;
      if (lat != W + 2 || nbusy != W + 1) begin
        n_err++;
        $display("FAIL basic_timing[%0d]: done cycle %0d busy cycles %0d, required %0d %0d",
                 i, lat, nbusy, W + 2, W + 1);
      end
      n_cmp++;
      if (observed() !== e) begin
        n_err++;
        $display("FAIL basic_result[%0d]: lo=%h hi=%h dbz=%b ovf=%b, required lo=%h hi=%h dbz=%b ovf=%b",
                 i, bus.lo, bus.hi, bus.div_by_zero, bus.overflow, e.lo, e.hi, e.dbz, e.ovf);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.done !== 1'b0 || observed() !== e) begin
        n_err++;
        $display("FAIL basic_pulse[%0d]: done=%b lo=%h after done cycle, required done=0 lo=%h",
                 i, bus.done, bus.lo, e.lo);
      end
    end
  endtask
  task automatic test_div_zero();
    int lat, nbusy;
    res_t e;
    for (int i = 0; i < 2; i++) begin
      issue(i == 0 ? 32'h1234 : 32'hFFFF_FF00, '0, i[0], 1'b1);
      n_cmp++;
      if (bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL dz_busy[%0d]: busy=%b, required 0", i, bus.busy);
      end
      wait_done(lat, nbusy);
      e = pop_exp();
      n_cmp++;
      if (lat != 1 || nbusy != 0 || observed() !== e) begin
        n_err++;
        $display("FAIL dz_result[%0d]: cycle %0d lo=%h hi=%h dbz=%b ovf=%b, required cycle 1 lo=%h hi=%h dbz=%b ovf=%b",
                 i, lat, bus.lo, bus.hi, bus.div_by_zero, bus.overflow, e.lo, e.hi, e.dbz, e.ovf);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_ignore_start();
    int lat, nbusy;
    res_t e;
    issue(32'd50, 32'd5, 1'b0, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    issue(32'd9, 32'd3, 1'b0, 1'b0);
    wait_done(lat, nbusy);
    e = pop_exp();
    n_cmp++;
    if (lat + 10 != W + 2 || nbusy != W + 1 - 10 || observed() !== e) begin
      n_err++;
      $display("FAIL ignore_start: done cycle %0d lo=%h hi=%h, required cycle %0d lo=%h hi=%h",
               lat + 10, bus.lo, bus.hi, W + 2, e.lo, e.hi);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_back_to_back();
    int lat, nbusy;
    res_t e;
    issue(32'd50, 32'd5, 1'b0, 1'b1);
    wait_done(lat, nbusy);
    e = pop_exp();
    n_cmp++;
    if (observed() !== e) begin
      n_err++;
      $display("FAIL b2b_first: lo=%h hi=%h, required lo=%h hi=%h", bus.lo, bus.hi, e.lo, e.hi);
    end
    issue(32'd9, 32'd3, 1'b0, 1'b1);
    n_cmp++;
    if (bus.busy !== 1'b1 || observed() !== e) begin
      n_err++;
      $display("FAIL b2b_accept: busy=%b lo=%h hi=%h, required busy=1 lo=%h hi=%h",
               bus.busy, bus.lo, bus.hi, e.lo, e.hi);
    end
    wait_done(lat, nbusy);
    e = pop_exp();
    n_cmp++;
    if (lat != W + 2 || observed() !== e) begin
      n_err++;
      $display("FAIL b2b_second: cycle %0d lo=%h hi=%h, required cycle %0d lo=%h hi=%h",
               lat, bus.lo, bus.hi, W + 2, e.lo, e.hi);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset_mid();
    int lat, nbusy, seen;
    res_t e;
    issue(32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.done, observed()} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_state: busy=%b done=%b lo=%h hi=%h, required all 0",
               bus.busy, bus.done, bus.lo, bus.hi);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (bus.done || bus.busy) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL reset_mid_quiet: %0d cycles with done/busy, required 0", seen);
    end
    issue(32'd1000, 32'd3, 1'b0, 1'b1);
    wait_done(lat, nbusy);
    e = pop_exp();
    n_cmp++;
    if (lat != W + 2 || observed() !== e) begin
      n_err++;
      $display("FAIL reset_mid_reissue: cycle %0d lo=%h hi=%h, required cycle %0d lo=%h hi=%h",
               lat, bus.lo, bus.hi, W + 2, e.lo, e.hi);
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
